stopwatch_counter: RTL

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

---
 rtl/stopwatch_counter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//
// Minutes:seconds stopwatch with run/pause control, a field-by-field
// adjust mode, and an optional lap (display freeze) feature.
//
// Parameters
//   MIN_MAX     highest minutes value before wrap (1..99)
//   SEC_MAX     highest seconds value before wrap (1..59)
//
// Ports
//   sys_clk     system clock, all logic on its rising edge
//   rst         synchronous active-high reset
//   onehz_clk   1 Hz square wave, sampled as data; rising edge = count tick
//   twohz_clk   2 Hz square wave, sampled as data; rising edge = adjust tick
//   pause_pulse single-cycle pulse toggling RUN/PAUSED (ignored in ADJUST)
//   adj         level, 1 = adjust mode
//   sel         adjust field select, 0 = seconds, 1 = minutes
//   lap_pulse   single-cycle pulse toggling display freeze
//   min_tens, min_ones, sec_tens, sec_ones   registered BCD digits
//   running     registered, 1 only in the RUN state
//
// Configuration
//   STOPWATCH_LAP_EN  when defined, lap_pulse freezes/unfreezes the digits
//                     while the count keeps advancing. When undefined,
//                     lap_pulse is ignored and the digits follow the count.

module stopwatch_counter #(
    parameter int MIN_MAX = 99,
    parameter int SEC_MAX = 59
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       onehz_clk,
    input  logic       twohz_clk,
    input  logic       pause_pulse,
    input  logic       adj,
    input  logic       sel,
    input  logic       lap_pulse,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running
);

    localparam logic [6:0] MIN_LIM = 7'(MIN_MAX);
    localparam logic [5:0] SEC_LIM = 6'(SEC_MAX);

    typedef enum logic [1:0] {
        ST_PAUSED = 2'd0,
        ST_RUN    = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    state_t     resume_state;
    state_t     resume_next;
    logic [6:0] min_cnt;
    logic [6:0] min_next;
    logic [5:0] sec_cnt;
    logic [5:0] sec_next;
    logic       onehz_prev;
    logic       twohz_prev;
    logic       primed;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       hold_display;

    // The edge history is cleared by reset, so a wave that is already high
    // would look like a fresh rising edge right after reset. 'primed' stays
    // low for that first cycle and masks it.
    assign tick_1hz = primed & onehz_clk & ~onehz_prev;
    assign tick_2hz = primed & twohz_clk & ~twohz_prev;

    // Mode control. adj has priority over everything; the mode held before
    // entering ADJUST is remembered so leaving ADJUST resumes it.
    always_comb begin
        state_next  = state;
        resume_next = resume_state;
        if (adj) begin
            if (state != ST_ADJUST) begin
                resume_next = state;
            end
            state_next = ST_ADJUST;
        end else if (state == ST_ADJUST) begin
            state_next = resume_state;
        end else if (pause_pulse) begin
            state_next = (state == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
    end

    // Count update follows the current state, so a tick arriving together
    // with a pause pulse still lands before the pause takes effect. In
    // ADJUST each field wraps on its own with no carry.
    always_comb begin
        min_next = min_cnt;
        sec_next = sec_cnt;
        case (state)
            ST_RUN: begin
                if (tick_1hz) begin
                    if (sec_cnt == SEC_LIM) begin
                        sec_next = 6'd0;
                        min_next = (min_cnt == MIN_LIM) ? 7'd0 : min_cnt + 7'd1;
                    end else begin
                        sec_next = sec_cnt + 6'd1;
                    end
                end
            end
            ST_ADJUST: begin
                if (tick_2hz) begin
                    if (sel) begin
                        min_next = (min_cnt == MIN_LIM) ? 7'd0 : min_cnt + 7'd1;
                    end else begin
                        sec_next = (sec_cnt == SEC_LIM) ? 6'd0 : sec_cnt + 6'd1;
                    end
                end
            end
            default: begin
                min_next = min_cnt;
                sec_next = sec_cnt;
            end
        endcase
    end

`ifdef STOPWATCH_LAP_EN
    logic freeze;
    logic freeze_next;

    // Adjusting a frozen display would be invisible, so adj forces the
    // freeze off.
    always_comb begin
        freeze_next = freeze;
        if (adj) begin
            freeze_next = 1'b0;
        end else if (lap_pulse) begin
            freeze_next = ~freeze;
        end
    end

    // The digits load on the cycle freeze turns on (capturing the live
    // value) and on the cycle it turns off; they hold only while freeze
    // stays set.
    assign hold_display = freeze & freeze_next;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            freeze <= 1'b0;
        end else begin
            freeze <= freeze_next;
        end
    end
`else
    logic unused_lap;

    assign unused_lap   = lap_pulse;
    assign hold_display = 1'b0;
`endif

    // State, count, edge history and the display registers. The digits are
    // converted from the registered count, so they trail it by one cycle.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state        <= ST_PAUSED;
            resume_state <= ST_PAUSED;
            min_cnt      <= 7'd0;
            sec_cnt      <= 6'd0;
            onehz_prev   <= 1'b0;
            twohz_prev   <= 1'b0;
            primed       <= 1'b0;
            running      <= 1'b0;
            min_tens     <= 4'd0;
            min_ones     <= 4'd0;
            sec_tens     <= 4'd0;
            sec_ones     <= 4'd0;
        end else begin
            state        <= state_next;
            resume_state <= resume_next;
            min_cnt      <= min_next;
            sec_cnt      <= sec_next;
            onehz_prev   <= onehz_clk;
            twohz_prev   <= twohz_clk;
            primed       <= 1'b1;
            running      <= (state_next == ST_RUN);
            if (!hold_display) begin
                min_tens <= 4'(min_cnt / 7'd10);
                min_ones <= 4'(min_cnt % 7'd10);
                sec_tens <= 4'(sec_cnt / 6'd10);
                sec_ones <= 4'(sec_cnt % 6'd10);
            end
        end
    end

endmodule
